// File: rtl/dma_seq_pkg.sv
// -----------------------------------------------------------------------------
// dma_seq_pkg
// Shared types for the DMA sequencer:
//   am_instr_e - 3-bit instruction codes driven to the address generator
//   state_e    - sequencer FSM states
//   desc_t     - descriptor captured on the command handshake
// -----------------------------------------------------------------------------
package dma_seq_pkg;

    localparam int BEAT_W = 9;  // wide enough to hold a full 256-beat count

    typedef enum logic [2:0] {
        WR_CR   = 3'd0,
        READ_CR = 3'd1,
        READ_WC = 3'd2,
        READ_AC = 3'd3,
        REINIT  = 3'd4,
        LD_ADDR = 3'd5,
        LD_WC   = 3'd6,
        ENABLE  = 3'd7
    } am_instr_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_CR,
        S_LD_AR,
        S_LD_WC,
        S_RUN,
        S_FIN
    } state_e;

    typedef struct packed {
        logic [1:0] mode;
        logic       dir;
        logic [7:0] addr;
        logic [7:0] count;
    } desc_t;

endpackage

// File: rtl/beat_counter.sv
// -----------------------------------------------------------------------------
// beat_counter
// 9-bit beat down-counter for the DMA sequencer.
//   clk, reset_n - clock, asynchronous active-low reset (count clears to 0)
//   load_i       - load count_i (a count of 0 loads 256)
//   count_i[7:0] - descriptor word count
//   dec_i        - decrement by one (saturates at 0)
//   beats_o[8:0] - beats remaining
//   is_last_o    - exactly one beat remains
// -----------------------------------------------------------------------------
module beat_counter
    import dma_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [7:0]        count_i,
    input  logic              dec_i,
    output logic [BEAT_W-1:0] beats_o,
    output logic              is_last_o
);

    logic [BEAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assign the default first so every path drives cnt_d; a missing
        // branch in always_comb would otherwise infer a latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (count_i == 8'd0) ? BEAT_W'(256) : {1'b0, count_i};
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - BEAT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign beats_o   = cnt_q;
    assign is_last_o = (cnt_q == BEAT_W'(1));

endmodule

// File: rtl/dma_sequencer.sv
// -----------------------------------------------------------------------------
// dma_sequencer
// Accepts one DMA descriptor at a time, programs the address generator
// (control, address, word count), then runs memory beats until the count is
// exhausted and reinitialises the generator.
//
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   abort                    - (only with DMA_SEQ_ABORT_EN) abandon descriptor
//   cmd_valid / cmd_ready    - descriptor handshake
//   cmd_mode, cmd_dir        - control register bits [1:0] and [2]
//   cmd_addr, cmd_count      - start address, word count (0 means 256)
//   am_i, am_data            - instruction and data to the address generator
//   am_aci, am_wci           - address/word counter carry-in enables
//   am_done                  - generator's terminal-count flag
//   beat_req / beat_ack      - memory beat handshake
//   busy, xfer_done, err     - status: in progress, completion pulse, sticky
//                              terminal-count mismatch
//
// Configuration macro: DMA_SEQ_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module dma_sequencer
    import dma_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
`ifdef DMA_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_count,
    output logic [2:0] am_i,
    output logic [7:0] am_data,
    output logic       am_aci,
    output logic       am_wci,
    input  logic       am_done,
    output logic       beat_req,
    input  logic       beat_ack,
    output logic       busy,
    output logic       xfer_done,
    output logic       err
);

    state_e            state_q, state_d;
    desc_t             desc_q, desc_d;
    logic              err_q, err_d;
    logic              cnt_load, cnt_dec;
    logic [BEAT_W-1:0] beats_left;
    logic              is_last;
    logic              abort_w;

`ifdef DMA_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    beat_counter u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (cnt_load),
        .count_i   (desc_q.count),
        .dec_i     (cnt_dec),
        .beats_o   (beats_left),
        .is_last_o (is_last)
    );

    always_comb begin
        state_d   = state_q;
        desc_d    = desc_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        am_i      = READ_CR;
        am_data   = 8'h00;
        am_aci    = 1'b0;
        am_wci    = 1'b0;
        beat_req  = 1'b0;
        xfer_done = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    desc_d  = '{mode: cmd_mode, dir: cmd_dir, addr: cmd_addr, count: cmd_count};
                    err_d   = 1'b0;
                    state_d = S_LD_CR;
                end
            end
            S_LD_CR: begin
                am_i    = WR_CR;
                am_data = {5'b0, desc_q.dir, desc_q.mode};
                state_d = S_LD_AR;
            end
            S_LD_AR: begin
                am_i    = LD_ADDR;
                am_data = desc_q.addr;
                state_d = S_LD_WC;
            end
            S_LD_WC: begin
                am_i     = LD_WC;
                am_data  = desc_q.count;
                cnt_load = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                am_i     = ENABLE;
                beat_req = 1'b1;
                // Generator counters advance combinationally with each accepted beat.
                am_aci   = beat_ack;
                am_wci   = beat_ack;
                if (beat_ack) begin
                    cnt_dec = 1'b1;
                    // Our count and the generator's terminal count must agree:
                    // done missing on the last beat or early on any other beat.
                    if (is_last) begin
                        if (!am_done) err_d = 1'b1;
                        state_d = S_FIN;
                    end else if (am_done) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                am_i      = REINIT;
                xfer_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort outranks everything in the active states. FIN is excluded so
        // an abort held there cannot stretch the completion pulse.
        if (abort_w && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d = S_FIN;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            desc_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dma_sequencer
// Directed self-checking bench for dma_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are sampled there or 1 unit later.
// -----------------------------------------------------------------------------
module tb_dma_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic       cmd_dir;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_count;
    logic [2:0] am_i;
    logic [7:0] am_data;
    logic       am_aci;
    logic       am_wci;
    logic       am_done;
    logic       beat_req;
    logic       beat_ack;
    logic       busy;
    logic       xfer_done;
    logic       err;
`ifdef DMA_SEQ_ABORT_EN
    logic       abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dma_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef DMA_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_dir   (cmd_dir),
        .cmd_addr  (cmd_addr),
        .cmd_count (cmd_count),
        .am_i      (am_i),
        .am_data   (am_data),
        .am_aci    (am_aci),
        .am_wci    (am_wci),
        .am_done   (am_done),
        .beat_req  (beat_req),
        .beat_ack  (beat_ack),
        .busy      (busy),
        .xfer_done (xfer_done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a descriptor in IDLE and walk through the three load states,
    // ending one unit after the edge that enters RUN.
    task automatic issue(input logic [1:0] mode, input logic dir,
                         input logic [7:0] addr, input logic [7:0] cnt);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_dir   = dir;
        cmd_addr  = addr;
        cmd_count = cnt;
        #1;
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_am_i", 32'(am_i), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("ldcr_am_i", 32'(am_i), 32'd0);
        check("ldcr_data", 32'(am_data), 32'({5'b0, dir, mode}));
        check("ldcr_err_clr", 32'(err), 32'd0);
        check("ldcr_busy", 32'(busy), 32'd1);
        check("ldcr_ready", 32'(cmd_ready), 32'd0);
        check("ldcr_breq", 32'(beat_req), 32'd0);
        tick();
        check("ldar_am_i", 32'(am_i), 32'd5);
        check("ldar_data", 32'(am_data), 32'(addr));
        check("ldar_breq", 32'(beat_req), 32'd0);
        tick();
        check("ldwc_am_i", 32'(am_i), 32'd6);
        check("ldwc_data", 32'(am_data), 32'(cnt));
        check("ldwc_breq", 32'(beat_req), 32'd0);
        tick();
        check("run_am_i", 32'(am_i), 32'd7);
        check("run_data", 32'(am_data), 32'd0);
        check("run_breq", 32'(beat_req), 32'd1);
    endtask

    task automatic beat(input logic done);
        beat_ack = 1'b1;
        am_done  = done;
        tick();
        beat_ack = 1'b0;
        am_done  = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_dir   = 1'b0;
        cmd_addr  = 8'h00;
        cmd_count = 8'h00;
        am_done   = 1'b0;
        beat_ack  = 1'b0;
`ifdef DMA_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        #2;
        // Reset state
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_breq", 32'(beat_req), 32'd0);
        check("rst_done", 32'(xfer_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_am_i", 32'(am_i), 32'd1);
        check("rst_data", 32'(am_data), 32'd0);
        check("rst_aci", 32'(am_aci), 32'd0);
        check("rst_wci", 32'(am_wci), 32'd0);
        check("rst_beats", 32'(dut.beats_left), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_hold_busy", 32'(busy), 32'd0);

        // Basic transfer: mode 3, increment, addr 10, three beats
        issue(2'd3, 1'b0, 8'h10, 8'd3);
        check("a_aci_noack", 32'(am_aci), 32'd0);
        beat_ack = 1'b1;
        #1;
        check("a_aci_ack", 32'(am_aci), 32'd1);
        check("a_wci_ack", 32'(am_wci), 32'd1);
        tick();
        beat_ack = 1'b0;
        check("a_run_b1", 32'(beat_req), 32'd1);
        check("a_nodone_b1", 32'(xfer_done), 32'd0);
        beat(1'b0);
        check("a_run_b2", 32'(beat_req), 32'd1);
        beat(1'b1);
        check("a_fin_done", 32'(xfer_done), 32'd1);
        check("a_fin_am_i", 32'(am_i), 32'd4);
        check("a_fin_data", 32'(am_data), 32'd0);
        check("a_fin_busy", 32'(busy), 32'd1);
        check("a_fin_breq", 32'(beat_req), 32'd0);
        check("a_fin_err", 32'(err), 32'd0);
        tick();
        check("a_idle_done", 32'(xfer_done), 32'd0);
        check("a_idle_busy", 32'(busy), 32'd0);
        check("a_idle_ready", 32'(cmd_ready), 32'd1);

        // Stall 10 cycles, then a last beat without am_done -> sticky err
        issue(2'd1, 1'b1, 8'h80, 8'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("b_stall_breq", 32'(beat_req), 32'd1);
            check("b_stall_aci", 32'(am_aci), 32'd0);
            check("b_stall_wci", 32'(am_wci), 32'd0);
        end
        check("b_stall_beats", 32'(dut.beats_left), 32'd2);
        beat(1'b0);
        check("b_b1_run", 32'(beat_req), 32'd1);
        check("b_b1_err", 32'(err), 32'd0);
        beat(1'b0);
        check("b_fin_done", 32'(xfer_done), 32'd1);
        check("b_fin_err", 32'(err), 32'd1);
        tick();
        check("b_idle_err", 32'(err), 32'd1);
        tick();
        check("b_idle_err2", 32'(err), 32'd1);

        // New descriptor clears err; am_done on a non-last beat sets it again
        issue(2'd2, 1'b0, 8'h40, 8'd2);
        beat(1'b1);
        check("c_early_err", 32'(err), 32'd1);
        check("c_early_run", 32'(xfer_done), 32'd0);
        beat(1'b1);
        check("c_fin_done", 32'(xfer_done), 32'd1);
        check("c_fin_err", 32'(err), 32'd1);
        tick();

        // count=1: the first beat is the last
        issue(2'd0, 1'b0, 8'h01, 8'd1);
        beat(1'b1);
        check("d1_fin_done", 32'(xfer_done), 32'd1);
        check("d1_fin_err", 32'(err), 32'd0);
        tick();

        // count=0 means 256 beats
        issue(2'd0, 1'b0, 8'h00, 8'd0);
        check("d_beats_256", 32'(dut.beats_left), 32'd256);
        for (int i = 0; i < 255; i++) beat(1'b0);
        check("d_255_run", 32'(beat_req), 32'd1);
        check("d_255_nodone", 32'(xfer_done), 32'd0);
        beat(1'b1);
        check("d_256_done", 32'(xfer_done), 32'd1);
        check("d_256_err", 32'(err), 32'd0);
        tick();

`ifdef DMA_SEQ_ABORT_EN
        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        check("e_idle_abort", 32'(busy), 32'd0);
        check("e_idle_abort_done", 32'(xfer_done), 32'd0);
        abort = 1'b0;
        // Abort during LD_AR -> FIN next cycle
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        cmd_dir   = 1'b0;
        cmd_addr  = 8'h22;
        cmd_count = 8'd4;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("e_ldar_am_i", 32'(am_i), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("e_fin_am_i", 32'(am_i), 32'd4);
        check("e_fin_done", 32'(xfer_done), 32'd1);
        check("e_fin_err", 32'(err), 32'd0);
        tick();
        check("e_idle_busy", 32'(busy), 32'd0);
        check("e_idle_done", 32'(xfer_done), 32'd0);
`endif

        // Reset during RUN after 1 of 5 beats
        issue(2'd0, 1'b1, 8'h30, 8'd5);
        beat(1'b0);
        reset_n = 1'b0;
        #1;
        check("r_busy", 32'(busy), 32'd0);
        check("r_breq", 32'(beat_req), 32'd0);
        check("r_ready", 32'(cmd_ready), 32'd1);
        check("r_am_i", 32'(am_i), 32'd1);
        check("r_done", 32'(xfer_done), 32'd0);
        check("r_beats", 32'(dut.beats_left), 32'd0);
        tick();
        check("r_done_hold", 32'(xfer_done), 32'd0);
        reset_n = 1'b1;
        tick();
        check("r_after_busy", 32'(busy), 32'd0);
        check("r_after_done", 32'(xfer_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_sequencer.md
DMA_SEQUENCER -- requirements
Module: dma_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port cmd_valid  input  1  descriptor offered.
REQ-004 SHALL have port cmd_ready  output  1  descriptor accepted when cmd_valid&cmd_ready.
REQ-005 SHALL have port cmd_mode  input  2  transfer mode, written to control register bits [1:0].
REQ-006 SHALL have port cmd_dir  input  1  address direction, written to control register bit [2] (0 increment, 1 decrement).
REQ-007 SHALL have port cmd_addr  input  8  start address.
REQ-008 SHALL have port cmd_count  input  8  word count (0 means 256).
REQ-009 SHALL have port am_i  output  3  instruction code to the address generator.
REQ-010 SHALL have port am_data  output  8  data bus to the address generator.
REQ-011 SHALL have port am_aci / am_wci  output  1 each  counter carry-in enables.
REQ-012 SHALL have port am_done  input  1  done flag from the address generator.
REQ-013 SHALL have port beat_req / beat_ack  output / input  1 each  memory beat handshake.
REQ-014 SHALL have port busy  output  1  descriptor in progress.
REQ-015 SHALL have port xfer_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port err  output  1  sticky done-mismatch flag.

Function
REQ-017 SHALL implement states IDLE, LD_CR, LD_AR, LD_WC, RUN, FIN.
REQ-018 IDLE: cmd_ready=1, am_i=READ_CR(1); on handshake latch descriptor, go LD_CR.
REQ-019 LD_CR: am_i=WR_CR(0), am_data={5'b0,cmd_dir,cmd_mode}; next LD_AR.
REQ-020 LD_AR: am_i=LD_ADDR(5), am_data=cmd_addr; next LD_WC.
REQ-021 LD_WC: am_i=LD_WC(6), am_data=cmd_count; internal beats_left loaded with cmd_count (9-bit, 0 loads 256); next RUN.
REQ-022 RUN: am_i=ENABLE(7), beat_req=1; am_aci=am_wci=beat_ack (combinational); each beat_ack decrements beats_left.
REQ-023 RUN: beat_ack with beats_left==1 SHALL go FIN; otherwise stay in RUN; beat_req held while beat_ack=0, no timeout.
REQ-024 On last beat, am_done=0 SHALL set err; am_done=1 on a non-last beat SHALL set err; transfer continues to beats_left in both cases.
REQ-025 FIN: xfer_done=1 for exactly one cycle, am_i=REINIT(4); next IDLE.
REQ-026 busy=1 in every state except IDLE; cmd_ready=0 outside IDLE (no descriptor queueing).
REQ-027 am_data SHALL be 8'h00 in IDLE, RUN and FIN.
REQ-028 err SHALL clear only on reset or on acceptance of a new descriptor.
REQ-029 Descriptor-to-first-beat_req latency SHALL be exactly 4 cycles after the handshake edge.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, cmd_ready=1, busy=0, beat_req=0, xfer_done=0, err=0, am_i=READ_CR(1), am_data=0, am_aci=am_wci=0, beats_left=0.
REQ-031 Reset mid-transfer SHALL abandon the descriptor with no xfer_done pulse.

Configuration
REQ-032 With DMA_SEQ_ABORT_EN defined, input abort (1 bit) SHALL, in any non-IDLE state, force FIN next cycle (REINIT issued, xfer_done pulsed, err unaffected); abort in IDLE is ignored.
REQ-033 Without DMA_SEQ_ABORT_EN, no abort port exists and behaviour is REQ-017..029 only.

Structure
REQ-034 Package dma_seq_pkg SHALL hold the 3-bit instruction enum (WR_CR=0..ENABLE=7) and the state enum.
REQ-035 Beat down-counter SHALL be sub-module beat_counter (9-bit, load/decrement/is_last).

Verification
REQ-036 Descriptor addr=8'h10, count=3 -> am_i sequence 0,5,6,7; am_data 03/10/03 as applicable; three beat_ack -> xfer_done one cycle after third ack, err=0.
REQ-037 count=0 -> exactly 256 beats accepted before FIN.
REQ-038 beat_ack stalled 10 cycles in RUN -> beat_req held, am_aci=am_wci=0, beats_left unchanged.
REQ-039 am_done held 0 on last beat of count=2 -> err=1 after FIN; next descriptor handshake -> err=0.
REQ-040 reset_n low during RUN after 1 of 5 beats -> next cycle IDLE, busy=0, no xfer_done.
REQ-041 (DMA_SEQ_ABORT_EN) abort during LD_AR -> FIN next cycle, am_i=4, xfer_done pulse, then IDLE.
